gen_step_ctrl: RTL and testbench
================================

Name: gen_step_ctrl

Overview:
- Consumer of the free-running 32-bit divider bus. Turns a selectable divider bit into single-cycle generation ticks.
- Drives a req/ack handshake to the Life-game update engine: one request per generation.
- Provides run/pause, single-step, a generation counter and an overrun flag.
- Sits between the clock-divider counter and the board-update engine, in the core clock domain.

Parameters:
- TAP_BASE, 20, divider bit index selected when speed = 0; speed s selects bit TAP_BASE+s.
- GEN_W, 16, width of the generation counter.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- clkdiv  in  32  free-running divider count
- speed  in  3  tick-rate select; 0 = fastest (bit TAP_BASE), 7 = slowest (bit TAP_BASE+7)
- run_toggle  in  1  one-cycle pulse, already debounced; flips run/pause
- step_btn  in  1  one-cycle pulse; requests one generation while paused
- clr_overrun  in  1  one-cycle pulse; clears the overrun flag
- step_req  out  1  level; asks the engine to compute one generation
- step_ack  in  1  one-cycle pulse from the engine; generation finished
- running  out  1  current run flag
- busy  out  1  high while step_req is outstanding
- gen_count  out  GEN_W  completed generations
- overrun  out  1  sticky; a tick arrived while busy

Behaviour:
- Reset is synchronous and active-high. Values after reset:
  - state = IDLE
  - running = 0, step_req = 0, busy = 0
  - gen_count = 0, overrun = 0
  - tap_q = 0, speed_q = 0
- Tap selection: sel = clkdiv[TAP_BASE+speed].
- Tick detection:
  - Register tap_q <= sel and speed_q <= speed every cycle.
  - tick = sel & ~tap_q & (speed == speed_q).
  - A speed change never produces a spurious tick in the cycle of the change.
- Run flag:
  - running toggles on run_toggle in any state, including BUSY.
  - A toggle during BUSY does not abort the handshake.
- States:
  - IDLE (paused): step_btn -> BUSY. A tick is ignored, and is not counted as overrun. If run_toggle sets running -> WAIT_TICK.
  - WAIT_TICK (running): tick -> BUSY. If run_toggle clears running -> IDLE. step_btn is ignored.
  - BUSY: step_req = 1 and busy = 1, registered, asserted the cycle after entry. On step_ack: gen_count += 1, then go to WAIT_TICK if running, else IDLE. step_req drops in the cycle after ack.
- Latency: a tick or step_btn in cycle N gives step_req high in cycle N+1.
- Overrun:
  - A tick while in BUSY sets overrun and the tick is dropped; it is never queued.
  - A tick in the same cycle as step_ack is treated as occurring in BUSY: overrun is set, the ack is still processed, and no new request is issued.
  - clr_overrun clears overrun. If a set and a clear coincide, set wins.
- step_ack outside BUSY is ignored: no count, no state change.
- gen_count wraps from 2^GEN_W-1 to 0 with no flag.
- step_btn and run_toggle in the same cycle while in IDLE: the toggle applies and step_btn is ignored. Next state is WAIT_TICK.
- Reset asserted mid-handshake drops step_req in the following cycle. The engine must tolerate a withdrawn request.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Decomposition:
- Shared package `lifegame_pkg`:
  - state encoding (IDLE, WAIT_TICK, BUSY)
  - GEN_W default
  - TAP_BASE default
- One natural sub-module, `tap_edge_det`: tap mux, tap_q/speed_q registers and the tick output. It can be reused by the display scroller.
- The FSM, counter and flags live in the top level.

Test Plan:
- Reset, then bench drives clkdiv with a counter, speed = 0, single run_toggle → after the first rising edge of bit 20, step_req rises next cycle. Ack 5 cycles later → gen_count = 1, step_req falls, state WAIT_TICK.
- Paused, step_btn pulse → step_req high next cycle. Ack → gen_count += 1, returns to IDLE. Further bit-20 edges produce no request.
- Running with ack withheld across two bit-20 rising edges → overrun = 1 and exactly one request is outstanding. Ack → gen_count += 1. clr_overrun → overrun = 0.
- Change speed 0→7 at a moment when bit 27 = 1 and tap_q = 0 → no tick that cycle. The next request aligns to a bit-27 rising edge.
- Preload gen_count to 0xFFFF via 65535 acked steps (or force), one more ack → gen_count = 0x0000, no other side effects.
- Assert rst while BUSY → step_req = 0, running = 0, gen_count = 0, overrun = 0 the cycle after reset. A late step_ack is ignored.

Source files
------------

// File: rtl/lifegame_pkg.sv
// Shared types and defaults for the Life-game generation control path.
package lifegame_pkg;

    localparam int unsigned DIV_W        = 32;
    localparam int unsigned SPEED_W      = 3;
    localparam int unsigned N_TAPS       = 8;
    localparam int unsigned TAP_BASE_DEF = 20;
    localparam int unsigned GEN_W_DEF    = 16;

    // Generation controller states
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,   // paused
        ST_WAIT_TICK = 2'd1,   // running, waiting for the next tick
        ST_BUSY      = 2'd2    // request outstanding to the update engine
    } gen_state_e;

endpackage

// File: rtl/tap_edge_det.sv
// Selects one divider bit by speed and emits a single-cycle tick on its
// rising edge.
//   clk, rst   : core clock, synchronous active-high reset
//   clkdiv     : free-running divider count
//   speed      : selects bit TAP_BASE+speed
//   tick_c     : combinational one-cycle tick (rising edge of selected bit)
module tap_edge_det
    import lifegame_pkg::*;
#(
    parameter int unsigned TAP_BASE = TAP_BASE_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DIV_W-1:0]   clkdiv,
    input  logic [SPEED_W-1:0] speed,
    output logic               tick_c
);

    logic [N_TAPS-1:0]  taps_c;
    logic               sel_c;
    logic               tap_d, tap_q;
    logic [SPEED_W-1:0] speed_d, speed_q;
    logic               unused_div_c;

    // Only the eight selectable bits matter; the rest is folded away.
    assign unused_div_c = ^clkdiv;

    always_comb begin
        taps_c  = clkdiv[TAP_BASE +: N_TAPS];
        sel_c   = taps_c[speed];
        tap_d   = sel_c;
        speed_d = speed;
        // A speed change compares against a different bit, so suppress that cycle.
        tick_c  = sel_c & ~tap_q & (speed == speed_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tap_q   <= 1'b0;
            speed_q <= '0;
        end else begin
            tap_q   <= tap_d;
            speed_q <= speed_d;
        end
    end

endmodule

// File: rtl/gen_step_ctrl.sv
// Generation step controller: turns divider ticks or step presses into one
// req/ack handshake per generation with the board-update engine.
//   clk, rst     : core clock, synchronous active-high reset
//   clkdiv       : free-running divider count
//   speed        : tick-rate select (0 fastest)
//   run_toggle   : pulse, flips run/pause
//   step_btn     : pulse, one generation while paused
//   clr_overrun  : pulse, clears overrun
//   step_req     : request level to the engine
//   step_ack     : pulse from the engine, generation done
//   running      : run flag
//   busy         : request outstanding
//   gen_count    : completed generations (wraps)
//   overrun      : sticky, tick arrived while busy
module gen_step_ctrl
    import lifegame_pkg::*;
#(
    parameter int unsigned TAP_BASE = TAP_BASE_DEF,
    parameter int unsigned GEN_W    = GEN_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DIV_W-1:0]   clkdiv,
    input  logic [SPEED_W-1:0] speed,
    input  logic               run_toggle,
    input  logic               step_btn,
    input  logic               clr_overrun,
    output logic               step_req,
    input  logic               step_ack,
    output logic               running,
    output logic               busy,
    output logic [GEN_W-1:0]   gen_count,
    output logic               overrun
);

    gen_state_e       state_d, state_q;
    logic             running_d, running_q;
    logic             step_req_d, step_req_q;
    logic             busy_d, busy_q;
    logic [GEN_W-1:0] gen_count_d, gen_count_q;
    logic             overrun_d, overrun_q;
    logic             tick_c;
    logic             ovr_set_c;

    tap_edge_det #(
        .TAP_BASE (TAP_BASE)
    ) u_tap (
        .clk    (clk),
        .rst    (rst),
        .clkdiv (clkdiv),
        .speed  (speed),
        .tick_c (tick_c)
    );

    // Next-state, counter and flag logic
    always_comb begin
        state_d     = state_q;
        running_d   = running_q ^ run_toggle;
        gen_count_d = gen_count_q;
        ovr_set_c   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Toggle has priority over a coincident step press.
                if (run_toggle) begin
                    state_d = ST_WAIT_TICK;
                end else if (step_btn) begin
                    state_d = ST_BUSY;
                end
            end
            ST_WAIT_TICK: begin
                if (run_toggle) begin
                    state_d = ST_IDLE;
                end else if (tick_c) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Ticks while busy are dropped, never queued.
                ovr_set_c = tick_c;
                if (step_ack) begin
                    gen_count_d = gen_count_q + GEN_W'(1);
                    state_d     = running_d ? ST_WAIT_TICK : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (ovr_set_c) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        step_req_d = (state_d == ST_BUSY);
        busy_d     = (state_d == ST_BUSY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            running_q   <= 1'b0;
            step_req_q  <= 1'b0;
            busy_q      <= 1'b0;
            gen_count_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            running_q   <= running_d;
            step_req_q  <= step_req_d;
            busy_q      <= busy_d;
            gen_count_q <= gen_count_d;
            overrun_q   <= overrun_d;
        end
    end

    assign step_req  = step_req_q;
    assign running   = running_q;
    assign busy      = busy_q;
    assign gen_count = gen_count_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_gen_step_ctrl.sv
// Directed bench for gen_step_ctrl; the counter is narrowed so wrap is reachable.
module tb_gen_step_ctrl;

    localparam int unsigned GEN_W = 8;
    localparam int unsigned B20   = 32'h0010_0000;
    localparam int unsigned B27   = 32'h0800_0000;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      clkdiv;
    logic [2:0]       speed;
    logic             run_toggle;
    logic             step_btn;
    logic             clr_overrun;
    logic             step_req;
    logic             step_ack;
    logic             running;
    logic             busy;
    logic [GEN_W-1:0] gen_count;
    logic             overrun;

    int n_cmp = 0;
    int n_err = 0;

    gen_step_ctrl #(
        .TAP_BASE (20),
        .GEN_W    (GEN_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clkdiv      (clkdiv),
        .speed       (speed),
        .run_toggle  (run_toggle),
        .step_btn    (step_btn),
        .clr_overrun (clr_overrun),
        .step_req    (step_req),
        .step_ack    (step_ack),
        .running     (running),
        .busy        (busy),
        .gen_count   (gen_count),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_toggle();
        run_toggle = 1'b1; cyc(); run_toggle = 1'b0;
    endtask

    task automatic pulse_step();
        step_btn = 1'b1; cyc(); step_btn = 1'b0;
    endtask

    task automatic pulse_ack();
        step_ack = 1'b1; cyc(); step_ack = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_overrun = 1'b1; cyc(); clr_overrun = 1'b0;
    endtask

    // Drive a rising edge on the given divider bit (low for a cycle, then high).
    task automatic edge_bit(input logic [31:0] bitv);
        clkdiv = 32'h0; cyc();
        clkdiv = bitv;  cyc();
    endtask

    initial begin
        rst = 1'b1; clkdiv = '0; speed = '0;
        run_toggle = 1'b0; step_btn = 1'b0; clr_overrun = 1'b0; step_ack = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        cyc();

        // Reset state
        chk("rst_step_req", 32'(step_req), 32'd0);
        chk("rst_running",  32'(running),  32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_gen",      32'(gen_count), 32'd0);
        chk("rst_overrun",  32'(overrun),  32'd0);

        // Run, first bit-20 rising edge requests next cycle
        pulse_toggle();
        chk("run_on", 32'(running), 32'd1);
        chk("run_no_req", 32'(step_req), 32'd0);
        clkdiv = B20; cyc();
        chk("tick_req", 32'(step_req), 32'd1);
        chk("tick_busy", 32'(busy), 32'd1);
        repeat (4) cyc();
        chk("req_held", 32'(step_req), 32'd1);
        pulse_ack();
        chk("ack_gen1", 32'(gen_count), 32'd1);
        chk("ack_req_drop", 32'(step_req), 32'd0);
        chk("ack_busy_drop", 32'(busy), 32'd0);
        edge_bit(B20);
        chk("wait_tick_req", 32'(step_req), 32'd1);

        // Overrun: second edge while ack withheld
        edge_bit(B20);
        chk("ovr_set", 32'(overrun), 32'd1);
        chk("ovr_one_req", 32'(step_req), 32'd1);
        pulse_ack();
        chk("ovr_gen2", 32'(gen_count), 32'd2);
        chk("ovr_req_drop", 32'(step_req), 32'd0);
        chk("ovr_sticky", 32'(overrun), 32'd1);
        pulse_clr();
        chk("ovr_clr", 32'(overrun), 32'd0);

        // Tick coincident with ack: overrun, ack counted, no new request
        edge_bit(B20);
        chk("co_req", 32'(step_req), 32'd1);
        clkdiv = 32'h0; cyc();
        clkdiv = B20; step_ack = 1'b1; cyc(); step_ack = 1'b0;
        chk("co_ovr", 32'(overrun), 32'd1);
        chk("co_gen3", 32'(gen_count), 32'd3);
        chk("co_no_req", 32'(step_req), 32'd0);
        cyc();
        chk("co_dropped", 32'(step_req), 32'd0);
        pulse_clr();
        chk("co_clr", 32'(overrun), 32'd0);

        // Set and clear together: set wins
        edge_bit(B20);
        clkdiv = 32'h0; cyc();
        clkdiv = B20; clr_overrun = 1'b1; cyc(); clr_overrun = 1'b0;
        chk("set_wins", 32'(overrun), 32'd1);
        pulse_ack();
        chk("sw_gen4", 32'(gen_count), 32'd4);
        pulse_clr();

        // Pause: ticks ignored, not overrun; step_btn works
        pulse_toggle();
        chk("pause", 32'(running), 32'd0);
        edge_bit(B20);
        chk("idle_no_req", 32'(step_req), 32'd0);
        chk("idle_no_ovr", 32'(overrun), 32'd0);
        pulse_step();
        chk("step_req", 32'(step_req), 32'd1);
        pulse_ack();
        chk("step_gen5", 32'(gen_count), 32'd5);
        chk("step_req_drop", 32'(step_req), 32'd0);
        edge_bit(B20);
        chk("idle_again", 32'(step_req), 32'd0);
        pulse_ack();
        chk("stray_ack", 32'(gen_count), 32'd5);

        // step_btn + run_toggle together in IDLE: toggle wins
        run_toggle = 1'b1; step_btn = 1'b1; cyc(); run_toggle = 1'b0; step_btn = 1'b0;
        chk("both_running", 32'(running), 32'd1);
        chk("both_no_req", 32'(step_req), 32'd0);
        pulse_step();
        chk("wait_step_ign", 32'(step_req), 32'd0);

        // Toggle during BUSY keeps the handshake, then returns to IDLE
        edge_bit(B20);
        chk("tb_req", 32'(step_req), 32'd1);
        pulse_toggle();
        chk("tb_running", 32'(running), 32'd0);
        chk("tb_req_kept", 32'(step_req), 32'd1);
        pulse_ack();
        chk("tb_gen6", 32'(gen_count), 32'd6);
        edge_bit(B20);
        chk("tb_idle", 32'(step_req), 32'd0);

        // Speed 0 -> 7 while bit 27 high and tap_q low: no spurious tick
        pulse_toggle();
        clkdiv = B27; cyc();
        speed = 3'd7; cyc();
        chk("spd_no_tick", 32'(step_req), 32'd0);
        cyc();
        chk("spd_no_tick2", 32'(step_req), 32'd0);
        clkdiv = B27 | B20; cyc();
        clkdiv = B27; cyc();
        clkdiv = B27 | B20; cyc();
        chk("spd_b20_ign", 32'(step_req), 32'd0);
        edge_bit(B27);
        chk("spd_b27_req", 32'(step_req), 32'd1);
        pulse_ack();
        chk("spd_gen7", 32'(gen_count), 32'd7);

        // Wrap the counter via paused single steps
        pulse_toggle();
        for (int i = 0; i < 248; i++) begin
            pulse_step();
            pulse_ack();
        end
        chk("pre_wrap", 32'(gen_count), 32'hFF);
        pulse_step();
        pulse_ack();
        chk("wrap_gen", 32'(gen_count), 32'h0);
        chk("wrap_ovr", 32'(overrun), 32'd0);
        chk("wrap_running", 32'(running), 32'd0);
        chk("wrap_req", 32'(step_req), 32'd0);

        // Reset mid-handshake
        pulse_step();
        pulse_toggle();
        edge_bit(B27);
        chk("pre_rst_ovr", 32'(overrun), 32'd1);
        chk("pre_rst_req", 32'(step_req), 32'd1);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("mrst_req", 32'(step_req), 32'd0);
        chk("mrst_running", 32'(running), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_gen", 32'(gen_count), 32'd0);
        chk("mrst_ovr", 32'(overrun), 32'd0);
        pulse_ack();
        chk("late_ack_gen", 32'(gen_count), 32'd0);
        chk("late_ack_req", 32'(step_req), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
